operand_issue: RTL and testbench

- Issue/writeback stage for the 16-bit CPU; this is the producer-side counterpart of the combinational ALU.
- Accepts one instruction per handshake and owns the 8x16 register file.
- Decodes the register fields, drives rddata/rsdata/rmdata/N/instruction to the ALU, captures aluout and writes it back to Rd.
- Multi-cycle; one instruction in flight at a time.

---
 rtl/operand_issue.sv | 151 +++++++++++++++
 tb/tb_operand_issue.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_issue.sv
// Issue/writeback stage for the 16-bit CPU: owns the register file, feeds operands to the ALU, and writes the result back.
// Optional build macro R0_ZERO_EN: R0 reads as zero and ignores every write.
module operand_issue #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [WIDTH-1:0] instr_in,
    output logic             instr_ready,
    input  logic             load_en,
    input  logic [2:0]       load_addr,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] instruction,
    output logic [WIDTH-1:0] rddata,
    output logic [WIDTH-1:0] rsdata,
    output logic [WIDTH-1:0] rmdata,
    output logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] aluout,
    output logic             wb_done,
    output logic             wb_wrote,
    output logic [1:0]       state_dbg
);

    // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
    // instr_ready is high only in IDLE, and upstream holds instr_in stable until the transfer.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] instruction_q;
    logic [WIDTH-1:0] rddata_q, rsdata_q, rmdata_q, n_q;
    logic [WIDTH-1:0] rddata_d, rsdata_d, rmdata_d, n_d;
    logic [WIDTH-1:0] result_q;
    logic             wb_done_q, wb_wrote_q;
    logic [WIDTH-1:0] regs_q [NREGS];

    logic             take, do_load, do_wb;
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;

    function automatic logic in_wb_set(input logic [4:0] op);
        case (op)
            5'b01000, 5'b01001, 5'b01010, 5'b01011,
            5'b01100, 5'b11000, 5'b11010: in_wb_set = 1'b1;
            default:                      in_wb_set = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        do_load = 1'b0;
        do_wb   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A transfer wins over a same-cycle load; that load is dropped.
                if (instr_valid) begin
                    take    = 1'b1;
                    state_d = S_READ;
                end else if (load_en) begin
                    do_load = 1'b1;
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB: begin
                do_wb   = in_wb_set(instr_q[15:11]);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rddata_d = regs_q[instr_q[10:8]];
        rsdata_d = regs_q[instr_q[7:5]];
        rmdata_d = regs_q[instr_q[4:2]];
        n_d      = {{(WIDTH-5){1'b0}}, instr_q[4:0]};
`ifdef R0_ZERO_EN
        if (instr_q[10:8] == 3'd0) rddata_d = '0;
        if (instr_q[7:5] == 3'd0)  rsdata_d = '0;
        if (instr_q[4:2] == 3'd0)  rmdata_d = '0;
`endif
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = load_addr;
        wr_data = load_data;
        if (do_load) begin
            wr_en = 1'b1;
        end else if (do_wb) begin
            wr_en   = 1'b1;
            wr_addr = instr_q[10:8];
            wr_data = result_q;
        end
`ifdef R0_ZERO_EN
        if (wr_addr == 3'd0) wr_en = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            instr_q       <= '0;
            instruction_q <= '0;
            rddata_q      <= '0;
            rsdata_q      <= '0;
            rmdata_q      <= '0;
            n_q           <= '0;
            result_q      <= '0;
            wb_done_q     <= 1'b0;
            wb_wrote_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (take) instr_q <= instr_in;
            // Operands are sampled before this instruction's own writeback, so Rd==Rs/Rm sees the old value.
            if (state_q == S_READ) begin
                instruction_q <= instr_q;
                rddata_q      <= rddata_d;
                rsdata_q      <= rsdata_d;
                rmdata_q      <= rmdata_d;
                n_q           <= n_d;
            end
            if (state_q == S_EXEC) result_q <= aluout;
            wb_done_q  <= (state_q == S_WB);
            wb_wrote_q <= do_wb;
            if (wr_en) regs_q[wr_addr] <= wr_data;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign instruction = instruction_q;
    assign rddata      = rddata_q;
    assign rsdata      = rsdata_q;
    assign rmdata      = rmdata_q;
    assign N           = n_q;
    assign wb_done     = wb_done_q;
    assign wb_wrote    = wb_wrote_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: a behavioural ALU closes the loop, a register model and an expected queue check every retirement.
module tb_operand_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr_in;
    logic        instr_ready;
    logic        load_en;
    logic [2:0]  load_addr;
    logic [15:0] load_data;
    logic [15:0] instruction, rddata, rsdata, rmdata, N;
    logic [15:0] aluout;
    logic        wb_done, wb_wrote;
    logic [1:0]  state_dbg;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Entry: {wb_wrote, instruction, rddata, rsdata, rmdata}
    logic [64:0] exp_q[$];
    logic [15:0] model_regs [8];

    always #5 clk = ~clk;

    operand_issue dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_in    (instr_in),
        .instr_ready (instr_ready),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .instruction (instruction),
        .rddata      (rddata),
        .rsdata      (rsdata),
        .rmdata      (rmdata),
        .N           (N),
        .aluout      (aluout),
        .wb_done     (wb_done),
        .wb_wrote    (wb_wrote),
        .state_dbg   (state_dbg)
    );

    function automatic logic [15:0] alu_fn(input logic [15:0] ins, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] c,
                                           input logic [15:0] n);
        case (ins[15:11])
            5'b01000: alu_fn = b + c;
            5'b01001: alu_fn = b + n;
            5'b01010: alu_fn = b - c;
            5'b01011: alu_fn = b - n;
            5'b01100: alu_fn = a * b + c;
            5'b11000: alu_fn = b & c;
            5'b11010: alu_fn = b | c;
            default:  alu_fn = b ^ c ^ 16'h5a5a;
        endcase
    endfunction

    function automatic logic writes_back(input logic [4:0] op);
        writes_back = (op == 5'b01000) || (op == 5'b01001) || (op == 5'b01010) ||
                      (op == 5'b01011) || (op == 5'b01100) || (op == 5'b11000) ||
                      (op == 5'b11010);
    endfunction

    function automatic logic [15:0] mread(input logic [2:0] a);
`ifdef R0_ZERO_EN
        if (a == 3'd0) return 16'h0000;
`endif
        return model_regs[a];
    endfunction

    function automatic logic r0_locked(input logic [2:0] a);
`ifdef R0_ZERO_EN
        return a == 3'd0;
`else
        return 1'b0 && (a == 3'd0);
`endif
    endfunction

    always_comb aluout = alu_fn(instruction, rddata, rsdata, rmdata, N);

    // Scoreboard: every retirement pops one expectation.
    always @(negedge clk) begin
        if (wb_done) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected_wb: wb_done=1 with no instruction outstanding");
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                total_cnt++;
                if (wb_wrote !== e[64]) $display("FAIL sb_wb_wrote: got %0b exp %0b", wb_wrote, e[64]);
                else pass_cnt++;
                total_cnt++;
                if (instruction !== e[63:48]) $display("FAIL sb_instruction: got %h exp %h", instruction, e[63:48]);
                else pass_cnt++;
                total_cnt++;
                if (rddata !== e[47:32]) $display("FAIL sb_rddata: got %h exp %h", rddata, e[47:32]);
                else pass_cnt++;
                total_cnt++;
                if (rsdata !== e[31:16]) $display("FAIL sb_rsdata: got %h exp %h", rsdata, e[31:16]);
                else pass_cnt++;
                total_cnt++;
                if (rmdata !== e[15:0]) $display("FAIL sb_rmdata: got %h exp %h", rmdata, e[15:0]);
                else pass_cnt++;
            end
        end
    end

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        if (!r0_locked(a)) model_regs[a] = d;
    endtask

    task automatic push_expect(input logic [15:0] ins);
        logic [15:0] a, b, c, n, res;
        logic        wr;
        a   = mread(ins[10:8]);
        b   = mread(ins[7:5]);
        c   = mread(ins[4:2]);
        n   = {11'b0, ins[4:0]};
        res = alu_fn(ins, a, b, c, n);
        wr  = writes_back(ins[15:11]);
        exp_q.push_back({wr, ins, a, b, c});
        if (wr && !r0_locked(ins[10:8])) model_regs[ins[10:8]] = res;
    endtask

    task automatic wait_wb(output int lat);
        lat = 0;
        while (!wb_done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!wb_done) begin
            total_cnt++;
            $display("FAIL wb_timeout: no wb_done within %0d cycles", lat);
        end
    endtask

    // Called at a negedge; returns at the negedge where wb_done is seen.
    task automatic issue(input logic [15:0] ins, output int lat);
        int guard;
        instr_valid = 1'b1;
        instr_in    = ins;
        guard = 0;
        while (!instr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        push_expect(ins);
        @(negedge clk);
        instr_valid = 1'b0;
        wait_wb(lat);
    endtask

    task automatic probe(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        int lat;
        issue({4'b0111, 1'b0, a, b, c, 2'b00}, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b0; instr_in = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        for (int i = 0; i < 8; i++) model_regs[i] = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %0b exp 1", instr_ready);
        else pass_cnt++;
        total_cnt++;
        if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d exp 0", state_dbg);
        else pass_cnt++;
        total_cnt++;
        if ({instruction, rddata, rsdata, rmdata, N} !== 80'h0)
            $display("FAIL reset_outputs: got %h %h %h %h %h exp all 0", instruction, rddata, rsdata, rmdata, N);
        else pass_cnt++;
        total_cnt++;
        if ({wb_done, wb_wrote} !== 2'b00) $display("FAIL reset_wb: got %b exp 00", {wb_done, wb_wrote});
        else pass_cnt++;
        probe(3'd1, 3'd2, 3'd3);
    endtask

    task automatic test_add();
        int lat;
        load(3'd1, 16'd5);
        load(3'd2, 16'd3);
        issue(16'h4128, lat);
        total_cnt++;
        if (lat !== 3) $display("FAIL add_latency: got %0d exp 3", lat);
        else pass_cnt++;
        total_cnt++;
        if (wb_wrote !== 1'b1) $display("FAIL add_wrote: got %0b exp 1", wb_wrote);
        else pass_cnt++;
        probe(3'd1, 3'd2, 3'd0);
        total_cnt++;
        if (rddata !== 16'd8) $display("FAIL add_r1: got %h exp 0008", rddata);
        else pass_cnt++;
    endtask

    task automatic test_sub_imm();
        int lat;
        load(3'd3, 16'd10);
        issue(16'h5C67, lat);
        total_cnt++;
        if (N !== 16'h0007) $display("FAIL subi_n: got %h exp 0007", N);
        else pass_cnt++;
        probe(3'd4, 3'd0, 3'd0);
        total_cnt++;
        if (rddata !== 16'd3) $display("FAIL subi_r4: got %h exp 0003", rddata);
        else pass_cnt++;
        load(3'd3, 16'd2);
        issue(16'h5C67, lat);
        probe(3'd4, 3'd0, 3'd0);
        total_cnt++;
        if (rddata !== 16'hFFFB) $display("FAIL subi_wrap: got %h exp fffb", rddata);
        else pass_cnt++;
    endtask

    task automatic test_mas_selfref();
        int lat;
        load(3'd1, 16'd2);
        load(3'd2, 16'd3);
        load(3'd3, 16'd4);
        issue(16'h614C, lat);
        total_cnt++;
        if (rddata !== 16'd2) $display("FAIL mas_old_rd: got %h exp 0002", rddata);
        else pass_cnt++;
        probe(3'd1, 3'd0, 3'd0);
        total_cnt++;
        if (rddata !== 16'd10) $display("FAIL mas_r1: got %h exp 000a", rddata);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        // Non-writeback opcode first, second instruction waits with valid held high.
        instr_valid = 1'b1;
        instr_in    = 16'h7100;
        total_cnt++;
        if (instr_ready !== 1'b1) $display("FAIL b2b_ready_idle: got %0b exp 1", instr_ready);
        else pass_cnt++;
        push_expect(16'h7100);
        @(negedge clk);
        instr_in = 16'h4128;
        push_expect(16'h4128);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (instr_ready !== 1'b0) $display("FAIL b2b_busy%0d: got %0b exp 0", i, instr_ready);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (instr_ready !== 1'b1) $display("FAIL b2b_ready_again: got %0b exp 1", instr_ready);
        else pass_cnt++;
        total_cnt++;
        if ({wb_done, wb_wrote} !== 2'b10) $display("FAIL b2b_nowb_retire: got %b exp 10", {wb_done, wb_wrote});
        else pass_cnt++;
        @(negedge clk);
        instr_valid = 1'b0;
        wait_wb(lat);
        total_cnt++;
        if (lat !== 3) $display("FAIL b2b_second_latency: got %0d exp 3", lat);
        else pass_cnt++;
        probe(3'd1, 3'd2, 3'd3);
    endtask

    task automatic test_reset_mid_exec();
        int pulses;
        load(3'd1, 16'd7);
        instr_valid = 1'b1;
        instr_in    = 16'h4128;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (state_dbg !== 2'd2) $display("FAIL rst_mid_in_exec: got %0d exp 2", state_dbg);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (state_dbg !== 2'd0) $display("FAIL rst_mid_state: got %0d exp 0", state_dbg);
        else pass_cnt++;
        total_cnt++;
        if ({rddata, rsdata, rmdata, N, instruction} !== 80'h0)
            $display("FAIL rst_mid_operands: got %h %h %h %h %h exp all 0", rddata, rsdata, rmdata, N, instruction);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) model_regs[i] = '0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wb_done) pulses++;
        end
        total_cnt++;
        if (pulses !== 0) $display("FAIL rst_mid_no_wb: got %0d pulses exp 0", pulses);
        else pass_cnt++;
        probe(3'd1, 3'd2, 3'd0);
        total_cnt++;
        if (rddata !== 16'd0) $display("FAIL rst_mid_r1: got %h exp 0000", rddata);
        else pass_cnt++;
    endtask

    task automatic test_r0();
        int lat;
        load(3'd0, 16'h1234);
        issue(16'h4500, lat);
        total_cnt++;
        if (wb_wrote !== 1'b1) $display("FAIL r0_wrote: got %0b exp 1", wb_wrote);
        else pass_cnt++;
        probe(3'd5, 3'd0, 3'd0);
`ifdef R0_ZERO_EN
        total_cnt++;
        if (rddata !== 16'h0000) $display("FAIL r0_r5: got %h exp 0000", rddata);
        else pass_cnt++;
`else
        total_cnt++;
        if (rddata !== 16'h2468) $display("FAIL r0_r5: got %h exp 2468", rddata);
        else pass_cnt++;
`endif
    endtask

    task automatic test_random();
        int          lat;
        logic [15:0] ins;
        logic [2:0]  a;
        for (int k = 0; k < 10; k++) begin
            a = 3'($urandom_range(0, 7));
            load(a, 16'($urandom()));
            ins = 16'($urandom());
            issue(ins, lat);
            total_cnt++;
            if (lat !== 3) $display("FAIL rand_latency%0d: got %0d exp 3", k, lat);
            else pass_cnt++;
        end
        probe(3'd0, 3'd1, 3'd2);
        probe(3'd3, 3'd4, 3'd5);
        probe(3'd6, 3'd7, 3'd0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_imm();
        test_mas_selfref();
        test_back_to_back();
        test_reset_mid_exec();
        test_r0();
        test_random();
        repeat (2) @(negedge clk);
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL sb_leftover: got %0d entries exp 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
